// File: rtl/alu_control_mc.sv
// Registered, handshaked ALU control unit with multi-cycle mult/div sequencing.
// Optional macro ALU_CTRL_SHIFT_EN enables the sll/srl/sra R-type decode.
module alu_control_mc #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [5:0] func,
    input  logic [2:0] alu_op,
    input  logic       ack,
    input  logic       err_clr,
    output logic       ready,
    output logic       finish,
    output logic [3:0] alu_control,
    output logic       multicycle,
    output logic       md_signed,
    output logic       err_illegal_func_code,
    output logic       err_illegal_alu_op,
    output logic       err_sticky
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

    typedef enum logic [3:0] {
        C_AND  = 4'b0000, C_OR   = 4'b0001, C_ADD  = 4'b0010, C_ADDU = 4'b0011,
        C_XOR  = 4'b0100, C_NOR  = 4'b0101, C_SUB  = 4'b0110, C_SLT  = 4'b0111,
        C_SUBU = 4'b1000, C_SLTU = 4'b1001, C_LUI  = 4'b1010, C_SLL  = 4'b1011,
        C_SRL  = 4'b1100, C_SRA  = 4'b1101, C_MULT = 4'b1110, C_DIV  = 4'b1111
    } ctrl_e;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ctrl_e            ctrl_q, ctrl_d;
    logic             multi_q, multi_d;
    logic             sgn_q, sgn_d;
    logic             err_func_q, err_func_d;
    logic             err_op_q, err_op_d;
    logic             sticky_q, sticky_d;

    ctrl_e dec_ctrl;
    logic  dec_multi, dec_is_mult, dec_signed, dec_err_func, dec_err_op;
    logic  accept;

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        dec_ctrl     = C_AND;
        dec_multi    = 1'b0;
        dec_is_mult  = 1'b0;
        dec_signed   = 1'b0;
        dec_err_func = 1'b0;
        dec_err_op   = 1'b0;
        case (alu_op)
            3'b000: dec_ctrl = C_ADD;
            3'b001: dec_ctrl = C_SUB;
            3'b011: dec_ctrl = C_AND;
            3'b100: dec_ctrl = C_OR;
            3'b101: dec_ctrl = C_SLT;
            3'b110: dec_ctrl = C_LUI;
            3'b111: dec_err_op = 1'b1;
            default: begin
                case (func)
                    6'b100000: dec_ctrl = C_ADD;
                    6'b100001: dec_ctrl = C_ADDU;
                    6'b100010: dec_ctrl = C_SUB;
                    6'b100011: dec_ctrl = C_SUBU;
                    6'b100100: dec_ctrl = C_AND;
                    6'b100101: dec_ctrl = C_OR;
                    6'b100110: dec_ctrl = C_XOR;
                    6'b100111: dec_ctrl = C_NOR;
                    6'b101010: dec_ctrl = C_SLT;
                    6'b101011: dec_ctrl = C_SLTU;
                    6'b011000, 6'b011001: begin
                        dec_ctrl    = C_MULT;
                        dec_multi   = 1'b1;
                        dec_is_mult = 1'b1;
                        dec_signed  = ~func[0];
                    end
                    6'b011010, 6'b011011: begin
                        dec_ctrl   = C_DIV;
                        dec_multi  = 1'b1;
                        dec_signed = ~func[0];
                    end
`ifdef ALU_CTRL_SHIFT_EN
                    6'b000000: dec_ctrl = C_SLL;
                    6'b000010: dec_ctrl = C_SRL;
                    6'b000011: dec_ctrl = C_SRA;
`endif
                    default: dec_err_func = 1'b1;
                endcase
            end
        endcase
    end

    assign ready  = (state_q == IDLE) || (state_q == DONE && ack);
    assign finish = (state_q == DONE);
    assign accept = start && ready;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ctrl_d     = ctrl_q;
        multi_d    = multi_q;
        sgn_d      = sgn_q;
        err_func_d = err_func_q;
        err_op_d   = err_op_q;
        sticky_d   = sticky_q;
        case (state_q)
            IDLE: ;
            EXEC: begin
                if (cnt_q == '0) state_d = DONE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            DONE:    if (ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A new accept overrides the DONE->IDLE move, giving back-to-back issue.
        if (accept) begin
            ctrl_d     = dec_ctrl;
            multi_d    = dec_multi;
            sgn_d      = dec_signed;
            err_func_d = dec_err_func;
            err_op_d   = dec_err_op;
            if (dec_multi) begin
                state_d = EXEC;
                cnt_d   = dec_is_mult ? MULT_LOAD : DIV_LOAD;
            end else begin
                state_d = DONE;
            end
        end
        if (err_clr) sticky_d = 1'b0;
        if (accept && (dec_err_func || dec_err_op)) sticky_d = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ctrl_q     <= C_AND;
            multi_q    <= 1'b0;
            sgn_q      <= 1'b0;
            err_func_q <= 1'b0;
            err_op_q   <= 1'b0;
            sticky_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ctrl_q     <= ctrl_d;
            multi_q    <= multi_d;
            sgn_q      <= sgn_d;
            err_func_q <= err_func_d;
            err_op_q   <= err_op_d;
            sticky_q   <= sticky_d;
        end
    end

    assign alu_control           = ctrl_q;
    assign multicycle            = multi_q;
    assign md_signed             = sgn_q;
    assign err_illegal_func_code = err_func_q;
    assign err_illegal_alu_op    = err_op_q;
    assign err_sticky            = sticky_q;

endmodule

// File: doc/alu_control_mc.md
Name: alu_control_mc

Overview:
Registered, handshaked ALU control unit; successor to the single-cycle combinational ALU decoder.
- Decodes a 3-bit ALUop plus the R-type func field into a 4-bit ALU control word.
- Adds immediate-class ops, unsigned ops and xor/nor.
- Sequences multi-cycle mult/div issue with a cycle counter before reporting completion.
- Sits between the main control FSM and the ALU/multiplier-divider datapath in the MIPS core.

Parameters:
MULT_CYCLES, 4, cycles from accept to finish for mult/multu; legal range 2..2**CNT_W.
DIV_CYCLES, 32, cycles from accept to finish for div/divu; legal range 2..2**CNT_W.
CNT_W, 6, width of the internal latency counter.

Ports:
clk  in  1  system clock; all state changes on rising edge.
rst_n  in  1  reset, synchronous, active-low.
start  in  1  request; sampled only when ready=1.
func  in  6  R-type function field; sampled with start.
alu_op  in  3  ALUop class; sampled with start.
ack  in  1  consumer acknowledges the result while finish=1.
err_clr  in  1  clears err_sticky.
ready  out  1  combinational: (state==IDLE) | (state==DONE & ack).
finish  out  1  result valid; high in DONE only.
alu_control  out  4  decoded ALU control word.
multicycle  out  1  accepted op is mult/multu/div/divu.
md_signed  out  1  mult/div is signed (mult, div).
err_illegal_func_code  out  1  illegal func for alu_op=010; valid with finish.
err_illegal_alu_op  out  1  alu_op=111; valid with finish.
err_sticky  out  1  OR of all errors since the last clear or reset.

Behaviour:
- Reset (rst_n=0 at an edge, any state, including mid-EXEC): state=IDLE, counter=0. All registered outputs are 0: finish, alu_control, multicycle, md_signed, both error flags, err_sticky. Any in-flight op is discarded.
- ALUop decode:
  - 000 mem -> add
  - 001 beq -> sub
  - 010 R-type -> func table
  - 011 andi -> and
  - 100 ori -> or
  - 101 slti -> slt
  - 110 lui -> lui
  - 111 -> illegal ALUop
  - func is ignored unless alu_op=010.
- Control encodings: and 0000, or 0001, add 0010, addu 0011, xor 0100, nor 0101, sub 0110, slt 0111, subu 1000, sltu 1001, lui 1010, sll 1011, srl 1100, sra 1101, mult 1110, div 1111. multu and divu reuse 1110/1111 with md_signed=0.
- func table: 100000 add, 100001 addu, 100010 sub, 100011 subu, 100100 and, 100101 or, 100110 xor, 100111 nor, 101010 slt, 101011 sltu, 011000 mult, 011001 multu, 011010 div, 011011 divu. Any other code is illegal.
- Illegal func or illegal ALUop: alu_control=0000, the matching err flag=1, err_sticky set, single-cycle latency.
- FSM states: IDLE, EXEC, DONE.
  - IDLE, start=1: latch the decode into output registers.
    - Single-cycle op or illegal -> DONE.
    - mult/multu -> EXEC, counter=MULT_CYCLES-1.
    - div/divu -> EXEC, counter=DIV_CYCLES-1.
  - EXEC: counter!=0 -> decrement; counter==0 -> DONE. start is ignored (ready=0).
  - DONE: finish=1; outputs held stable. ack=0 -> stay.
    - ack=1, start=0 -> IDLE; finish deasserts next cycle.
    - ack=1, start=1 -> back-to-back accept of the new op, same transitions as IDLE.
- Latency (start accepted at edge k):
  - single-cycle op: finish=1 after edge k.
  - multi-cycle op: finish=1 after edge k+N, where N=MULT_CYCLES or DIV_CYCLES.
- In IDLE, outputs keep their last values except finish=0.
- err_sticky: set on any accepted illegal op; cleared by err_clr. Set wins if a new error and err_clr land on the same edge.
- No $display in synthesizable paths.

Optional Feature:
- Macro ALU_CTRL_SHIFT_EN.
- Defined: func 000000 sll, 000010 srl, 000011 sra decode to 1011/1100/1101, single-cycle.
- Undefined: those func codes are illegal (err_illegal_func_code=1, alu_control=0000). Encodings 1011..1101 are never produced.

Test Plan:
- Reset mid-EXEC: accept div, pull rst_n low for 1 cycle at cycle 5 -> next cycle state IDLE, finish=0, err_sticky=0, ready=1.
- alu_op=010, func=100010, start pulse -> finish=1 one cycle later, alu_control=0110, errors 0. ack=1 -> finish=0 next cycle.
- alu_op=010, func=011001 (multu) with MULT_CYCLES=4 -> ready=0 for 4 cycles, finish=1 exactly 4 cycles after accept, alu_control=1110, md_signed=0, multicycle=1.
- Back-to-back: in DONE, ack=1 and start=1 with alu_op=110 -> no IDLE gap; next cycle finish=1, alu_control=1010.
- alu_op=111 -> err_illegal_alu_op=1, alu_control=0000, err_sticky=1. err_clr together with a second illegal op -> err_sticky stays 1. err_clr alone -> 0.
- func=000011, alu_op=010: with ALU_CTRL_SHIFT_EN defined -> alu_control=1101, no error. Undefined -> err_illegal_func_code=1, alu_control=0000.
